jtframe_rom_arb: RTL and testbench
==================================

// Module: jtframe_rom_arb
// PURPOSE
//  Parametrised N-slot ROM request arbiter between game-side ROM clients (main CPU, char, scroll,
//  obj, sound...) and the single SDRAM read port. Each slot has a one-word (32-bit) tag cache and
//  a fixed SDRAM offset. Successor to the fixed-slot ROM block used in the game tops; slot count,
//  address width and arbitration policy are parameters/macros instead of hard-wired ports.
// PARAMETERS
//  SLOTS   4        number of request slots (1..8)
//  AW      22       SDRAM word-address width; also slot address width
//  OFFSET  {SLOTS*AW{1'b0}}  packed per-slot SDRAM base; slot i uses OFFSET[i*AW+:AW]
// PORTS
//  clk          in   1           system clock (48 MHz)
//  rst          in   1           asynchronous, active-high reset
//  downloading  in   1           ROM download in progress; blocks all reads
//  slot_cs      in   SLOTS       per-slot read request (level)
//  slot_addr    in   SLOTS*AW    per-slot word address, packed, slot i at [i*AW+:AW]
//  slot_ok      out  SLOTS       slot_dout valid for current slot_addr
//  slot_dout    out  SLOTS*32    per-slot cached word, packed
//  sdram_req    out  1           read request to SDRAM controller
//  sdram_ack    in   1           controller accepted request
//  data_rdy     in   1           data_read valid this cycle
//  sdram_addr   out  AW          SDRAM word address
//  data_read    in   32          SDRAM read data
//  refresh_en   out  1           high when arbiter idle with nothing pending
// BEHAVIOUR
//  - Clock clk, reset rst: asynchronous, active-high. Reset: sdram_req=0, sdram_addr=0,
//    refresh_en=1, all slot_ok=0, all slot_dout=0, all cache valid=0, FSM=IDLE, rr pointer=0.
//  - Per-slot cache: valid, tag[AW], data[32]. hit_i = valid_i & (tag_i==slot_addr_i).
//    slot_ok_i = slot_cs_i & hit_i (combinational). slot_dout_i = data_i (registered).
//  - pending_i = slot_cs_i & ~hit_i & ~downloading.
//  - FSM IDLE: if any pending, grant slot g (policy below), latch gaddr=slot_addr_g,
//    sdram_addr <= slot_addr_g + OFFSET_g (mod 2^AW, carry dropped), sdram_req<=1, -> WAIT_ACK.
//    sdram_req rises the cycle after the miss is first visible (1-cycle request latency).
//  - WAIT_ACK: hold sdram_req and sdram_addr stable; on sdram_ack: sdram_req<=0, -> WAIT_DATA.
//  - WAIT_DATA: on data_rdy: data_g<=data_read, tag_g<=gaddr, valid_g<=1, -> IDLE.
//    slot_ok_g rises the cycle after data_rdy if slot_addr_g still equals gaddr.
//  - data_rdy coincident with sdram_ack in WAIT_ACK: both taken; cache written, -> IDLE.
//  - Slot address changes mid-fetch: fetch completes, cache stores old gaddr tag; slot_ok stays
//    low; slot re-arbitrates as pending next IDLE. No request is aborted.
//  - slot_cs dropped mid-fetch: fetch completes and is cached; no effect on other slots.
//  - Round-robin: search starts at slot rr+1 (mod SLOTS) and wraps; rr <= g on grant.
//    A continuously pending slot waits at most SLOTS-1 grants.
//  - IDLE with no pending: refresh_en=1; any other state or pending: refresh_en=0.
//  - downloading=1: all valid cleared every cycle, sdram_req forced 0, FSM forced IDLE
//    synchronously, any outstanding data_rdy ignored. Normal operation resumes the cycle after
//    downloading falls.
//  - SLOTS=1: arbiter degenerates to single-slot fetch; rr pointer unused.
// CONFIGURATION
//  JTFRAME_ROM_PRIO_EN defined: slot 0 has fixed top priority (granted whenever pending in
//    IDLE); slots 1..SLOTS-1 round-robin among themselves. Undefined: plain round-robin over all.
// TESTING
//  1 Reset: rst pulse mid-WAIT_DATA -> sdram_req=0, slot_ok=0, refresh_en=1 immediately (async).
//  2 Single miss: slot1 cs, addr=0x100, OFFSET1=0x8000 -> sdram_addr=0x8100, req 1 cycle later;
//    ack, data_rdy with 0xDEADBEEF -> slot_ok[1]=1, slot_dout1=0xDEADBEEF; same addr again: hit,
//    no new req.
//  3 Round-robin: slots 0..3 all missing simultaneously -> grant order 0,1,2,3 from rr=3;
//    with JTFRAME_ROM_PRIO_EN and slot0 re-missing each time -> slot0 granted every IDLE.
//  4 Addr change mid-fetch: slot2 0x10 -> 0x11 during WAIT_DATA -> slot_ok[2] stays 0, second
//    request for 0x11 issued; slot_ok[2]=1 after second data_rdy.
//  5 Offset wrap: AW=22, OFFSET=0x3FFFF0, addr=0x20 -> sdram_addr=0x000010.
//  6 Download: downloading=1 during WAIT_ACK -> req drops next cycle, all slot_ok=0; after
//    downloading=0 previously cached addresses miss and refetch.

Source files
------------

// File: rtl/jtframe_rom_arb_if.sv
// Bus bundle between the ROM arbiter, its game-side slot clients and the
// SDRAM read port. "master" is the arbiter view, "slave" the environment view.
interface jtframe_rom_arb_if #(
  parameter int SLOTS = 4,
  parameter int AW    = 22
);
  logic                  downloading;
  logic [SLOTS-1:0]      slot_cs;
  logic [SLOTS*AW-1:0]   slot_addr;
  logic [SLOTS-1:0]      slot_ok;
  logic [SLOTS*32-1:0]   slot_dout;
  logic                  sdram_req;
  logic                  sdram_ack;
  logic                  data_rdy;
  logic [AW-1:0]         sdram_addr;
  logic [31:0]           data_read;
  logic                  refresh_en;

  modport master (
    input  downloading, slot_cs, slot_addr, sdram_ack, data_rdy, data_read,
    output slot_ok, slot_dout, sdram_req, sdram_addr, refresh_en
  );

  modport slave (
    output downloading, slot_cs, slot_addr, sdram_ack, data_rdy, data_read,
    input  slot_ok, slot_dout, sdram_req, sdram_addr, refresh_en
  );
endinterface

// File: rtl/jtframe_rom_arb.sv
// N-slot ROM request arbiter: each slot owns a one-word tag cache and a fixed
// SDRAM base offset; misses are fetched one at a time through the SDRAM port.
// Build option: define JTFRAME_ROM_PRIO_EN to give slot 0 fixed top priority
// (remaining slots round-robin among themselves); otherwise all slots share a
// plain round-robin.
module jtframe_rom_arb #(
  parameter int                  SLOTS  = 4,
  parameter int                  AW     = 22,
  parameter logic [SLOTS*AW-1:0] OFFSET = '0
) (
  input  logic              clk,
  input  logic              rst,
  jtframe_rom_arb_if.master bus
);
  localparam int RRW = (SLOTS > 1) ? $clog2(SLOTS) : 1;

  typedef enum logic [1:0] {IDLE, WAIT_ACK, WAIT_DATA} state_t;

  state_t           state_q;
  logic [RRW-1:0]   rr_q;
  logic [RRW-1:0]   gsel_q;
  logic [AW-1:0]    gaddr_q;
  logic [AW-1:0]    sdram_addr_q;
  logic             req_q;

  logic [SLOTS-1:0] hit;
  logic [SLOTS-1:0] pending;
  logic             any_pending;
  logic             fill;
  logic [RRW-1:0]   gnt_d;
  logic [AW-1:0]    gaddr_d;
  logic [AW-1:0]    goff_d;
  logic             found;
  int               idx;

  assign any_pending = |pending;

  // A fetch completes on data_rdy in WAIT_DATA, or when data arrives together with the ack.
  assign fill = ~bus.downloading & bus.data_rdy &
                ((state_q == WAIT_DATA) | ((state_q == WAIT_ACK) & bus.sdram_ack));

  assign bus.sdram_req  = req_q;
  assign bus.sdram_addr = sdram_addr_q;
  // While reset is held the arbiter reports idle even if clients are already requesting.
  assign bus.refresh_en = (state_q == IDLE) & (rst | ~any_pending);

  genvar gi;
  generate
    for (gi = 0; gi < SLOTS; gi++) begin : g_slot
      logic          valid_q;
      logic [AW-1:0] tag_q;
      logic [31:0]   data_q;

      assign hit[gi]     = valid_q & (tag_q == bus.slot_addr[gi*AW +: AW]) & ~bus.downloading;
      assign pending[gi] = bus.slot_cs[gi] & ~hit[gi] & ~bus.downloading;
      assign bus.slot_ok[gi]           = bus.slot_cs[gi] & hit[gi];
      assign bus.slot_dout[gi*32 +: 32] = data_q;

      // Per-slot cache line: invalidated during download, written when its fetch returns.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          valid_q <= 1'b0;
          tag_q   <= '0;
          data_q  <= '0;
        end else if (bus.downloading) begin
          valid_q <= 1'b0;
        end else if (fill && (gsel_q == RRW'(gi))) begin
          valid_q <= 1'b1;
          tag_q   <= gaddr_q;
          data_q  <= bus.data_read;
        end
      end
    end
  endgenerate

  // Grant selection: search starts after the last granted slot and wraps around.
  always_comb begin
    gnt_d = '0;
    found = 1'b0;
    idx   = 0;
`ifdef JTFRAME_ROM_PRIO_EN
    if (pending[0]) begin
      found = 1'b1;
    end
`endif
    for (int k = 1; k <= SLOTS; k++) begin
      idx = (int'(rr_q) + k) % SLOTS;
      if (!found && pending[idx]) begin
        found = 1'b1;
        gnt_d = RRW'(idx);
      end
    end
    gaddr_d = bus.slot_addr[int'(gnt_d)*AW +: AW];
    goff_d  = OFFSET[int'(gnt_d)*AW +: AW];
  end

  // Request sequencer: one outstanding SDRAM read at a time, never aborted except by download.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      req_q        <= 1'b0;
      sdram_addr_q <= '0;
      gaddr_q      <= '0;
      gsel_q       <= '0;
      rr_q         <= '0;
    end else if (bus.downloading) begin
      state_q <= IDLE;
      req_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (any_pending) begin
            gsel_q       <= gnt_d;
            rr_q         <= gnt_d;
            gaddr_q      <= gaddr_d;
            sdram_addr_q <= gaddr_d + goff_d;
            req_q        <= 1'b1;
            state_q      <= WAIT_ACK;
          end
        end
        WAIT_ACK: begin
          if (bus.sdram_ack) begin
            req_q   <= 1'b0;
            state_q <= bus.data_rdy ? IDLE : WAIT_DATA;
          end
        end
        WAIT_DATA: begin
          if (bus.data_rdy) begin
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_jtframe_rom_arb.sv
// Bench for jtframe_rom_arb: directed vector table, directed multi-cycle
// sequences, then randomized traffic against a transaction-level model.
module tb_jtframe_rom_arb;
  localparam int NS = 4;
  localparam int AW = 22;
  localparam logic [AW-1:0] OFFS [NS] = '{22'h001000, 22'h008000, 22'h000200, 22'h3FFFF0};
  localparam logic [NS*AW-1:0] OFF_PK = {22'h3FFFF0, 22'h000200, 22'h008000, 22'h001000};

  logic clk = 1'b0;
  logic rst = 1'b1;
  int tests = 0;
  int fails = 0;

  jtframe_rom_arb_if #(.SLOTS(NS), .AW(AW)) bus ();

  jtframe_rom_arb #(.SLOTS(NS), .AW(AW), .OFFSET(OFF_PK)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.master)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  cs;
    logic [21:0] a1;
    logic        ack;
    logic        rdy;
    logic [31:0] d;
    logic        ereq;
    logic [21:0] eaddr;
    logic [3:0]  eok;
    logic        eref;
    logic [31:0] edout1;
  } vec_t;

  vec_t vecs [7];

  // model state
  logic        m_valid [NS];
  logic [21:0] m_tag   [NS];
  logic [31:0] m_data  [NS];
  bit          m_busy, m_acked;
  int          m_g, m_rr;
  logic [21:0] m_gaddr, m_raddr;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic set_addr(input int i, input logic [21:0] a);
    bus.slot_addr[i*AW +: AW] = a;
  endtask

  function automatic logic [21:0] get_addr(input int i);
    return bus.slot_addr[i*AW +: AW];
  endfunction

  task automatic wait_req(input string name, input logic [21:0] exp_addr);
    int n = 0;
    #1;
    while (bus.sdram_req !== 1'b1 && n < 20) begin
      @(negedge clk); #1;
      n++;
    end
    chk({name, " req"}, 128'(bus.sdram_req), 128'(1'b1));
    chk({name, " addr"}, 128'(bus.sdram_addr), 128'(exp_addr));
  endtask

  task automatic fetch(input string name, input logic [21:0] exp_addr, input logic [31:0] d);
    wait_req(name, exp_addr);
    bus.sdram_ack = 1'b1;
    @(negedge clk);
    bus.sdram_ack = 1'b0;
    bus.data_rdy  = 1'b1;
    bus.data_read = d;
    @(negedge clk);
    bus.data_rdy = 1'b0;
    #1;
  endtask

  function automatic int pick(input logic [3:0] p, input int rr);
`ifdef JTFRAME_ROM_PRIO_EN
    if (p[0]) return 0;
`endif
    for (int k = 1; k <= NS; k++) begin
      if (p[(rr + k) % NS]) return (rr + k) % NS;
    end
    return -1;
  endfunction

  initial begin
    bus.downloading = 1'b0;
    bus.slot_cs     = '0;
    bus.slot_addr   = '0;
    bus.sdram_ack   = 1'b0;
    bus.data_rdy    = 1'b0;
    bus.data_read   = '0;

    // reset state
    #1;
    chk("reset req", 128'(bus.sdram_req), 128'(1'b0));
    chk("reset addr", 128'(bus.sdram_addr), 128'(0));
    chk("reset refresh", 128'(bus.refresh_en), 128'(1'b1));
    chk("reset ok", 128'(bus.slot_ok), 128'(0));
    chk("reset dout", 128'(bus.slot_dout), 128'(0));
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    // single miss on slot 1, then hit
    vecs[0] = '{4'b0010, 22'h100, 1'b0, 1'b0, 32'h0,        1'b0, 22'h0,    4'b0000, 1'b0, 32'h0};
    vecs[1] = '{4'b0010, 22'h100, 1'b0, 1'b0, 32'h0,        1'b1, 22'h8100, 4'b0000, 1'b0, 32'h0};
    vecs[2] = '{4'b0010, 22'h100, 1'b1, 1'b0, 32'h0,        1'b1, 22'h8100, 4'b0000, 1'b0, 32'h0};
    vecs[3] = '{4'b0010, 22'h100, 1'b0, 1'b0, 32'h0,        1'b0, 22'h8100, 4'b0000, 1'b0, 32'h0};
    vecs[4] = '{4'b0010, 22'h100, 1'b0, 1'b1, 32'hDEADBEEF, 1'b0, 22'h8100, 4'b0000, 1'b0, 32'h0};
    vecs[5] = '{4'b0010, 22'h100, 1'b0, 1'b0, 32'h0,        1'b0, 22'h8100, 4'b0010, 1'b1, 32'hDEADBEEF};
    vecs[6] = '{4'b0010, 22'h100, 1'b0, 1'b0, 32'h0,        1'b0, 22'h8100, 4'b0010, 1'b1, 32'hDEADBEEF};
    for (int v = 0; v < 7; v++) begin
      @(negedge clk);
      bus.slot_cs   = vecs[v].cs;
      set_addr(1, vecs[v].a1);
      bus.sdram_ack = vecs[v].ack;
      bus.data_rdy  = vecs[v].rdy;
      bus.data_read = vecs[v].d;
      #1;
      chk($sformatf("vec%0d req", v), 128'(bus.sdram_req), 128'(vecs[v].ereq));
      chk($sformatf("vec%0d addr", v), 128'(bus.sdram_addr), 128'(vecs[v].eaddr));
      chk($sformatf("vec%0d ok", v), 128'(bus.slot_ok), 128'(vecs[v].eok));
      chk($sformatf("vec%0d refresh", v), 128'(bus.refresh_en), 128'(vecs[v].eref));
      chk($sformatf("vec%0d dout1", v), 128'(bus.slot_dout[63:32]), 128'(vecs[v].edout1));
    end
    @(negedge clk);
    bus.data_rdy = 1'b0;

    // offset wrap on slot 3 (leaves rr pointing at slot 3)
    bus.slot_cs = 4'b1000;
    set_addr(3, 22'h20);
    fetch("wrap", 22'h000010, 32'h33330020);
    chk("wrap ok", 128'(bus.slot_ok), 128'(4'b1000));
    chk("wrap dout3", 128'(bus.slot_dout[127:96]), 128'(32'h33330020));

    // all four slots miss together: order 0,1,2,3
    @(negedge clk);
    for (int i = 0; i < NS; i++) set_addr(i, 22'(32'h40 + i));
    bus.slot_cs = 4'b1111;
    for (int i = 0; i < NS; i++)
      fetch($sformatf("rr%0d", i), 22'(OFFS[i] + 22'(32'h40 + i)), 32'hA0 + i);
    chk("rr ok", 128'(bus.slot_ok), 128'(4'b1111));
    chk("rr refresh", 128'(bus.refresh_en), 128'(1'b1));
    chk("rr dout", 128'(bus.slot_dout), {32'hA3, 32'hA2, 32'hA1, 32'hA0});

    // slot 2 address changes while its fetch is outstanding
    @(negedge clk);
    bus.slot_cs = 4'b0100;
    set_addr(2, 22'h10);
    wait_req("chg", 22'h210);
    bus.sdram_ack = 1'b1;
    @(negedge clk);
    bus.sdram_ack = 1'b0;
    set_addr(2, 22'h11);
    @(negedge clk);
    bus.data_rdy  = 1'b1;
    bus.data_read = 32'h1111_0010;
    @(negedge clk);
    bus.data_rdy = 1'b0;
    #1;
    chk("chg ok stale", 128'(bus.slot_ok), 128'(4'b0000));
    fetch("chg2", 22'h211, 32'h1111_0011);
    chk("chg ok", 128'(bus.slot_ok), 128'(4'b0100));
    chk("chg dout2", 128'(bus.slot_dout[95:64]), 128'(32'h1111_0011));

    // download during WAIT_ACK
    @(negedge clk);
    set_addr(0, 22'h40);
    set_addr(1, 22'h41);
    set_addr(2, 22'h77);
    bus.slot_cs = 4'b0111;
    #1;
    chk("dl pre ok", 128'(bus.slot_ok), 128'(4'b0011));
    wait_req("dl", 22'h277);
    bus.downloading = 1'b1;
    @(negedge clk); #1;
    chk("dl req", 128'(bus.sdram_req), 128'(1'b0));
    chk("dl ok", 128'(bus.slot_ok), 128'(4'b0000));
    @(negedge clk);
    bus.downloading = 1'b0;
    #1;
    chk("dl post ok", 128'(bus.slot_ok), 128'(4'b0000));
    chk("dl post refresh", 128'(bus.refresh_en), 128'(1'b0));
    fetch("dl f0", 22'h1040, 32'hB0);
    fetch("dl f1", 22'h8041, 32'hB1);
    fetch("dl f2", 22'h0277, 32'hB2);
    chk("dl refill ok", 128'(bus.slot_ok), 128'(4'b0111));

    // asynchronous reset while waiting for data
    @(negedge clk);
    bus.slot_cs = 4'b1000;
    set_addr(3, 22'h99);
    wait_req("arst", 22'h000089);
    bus.sdram_ack = 1'b1;
    @(negedge clk);
    bus.sdram_ack = 1'b0;
    #1;
    rst = 1'b1;
    #1;
    chk("arst req", 128'(bus.sdram_req), 128'(1'b0));
    chk("arst ok", 128'(bus.slot_ok), 128'(4'b0000));
    chk("arst refresh", 128'(bus.refresh_en), 128'(1'b1));
    chk("arst dout", 128'(bus.slot_dout), 128'(0));

    // randomized traffic against the model
    for (int i = 0; i < NS; i++) begin
      m_valid[i] = 1'b0;
      m_tag[i]   = '0;
      m_data[i]  = '0;
    end
    m_busy = 0; m_acked = 0; m_g = 0; m_rr = 0; m_gaddr = '0; m_raddr = '0;
    @(negedge clk);
    bus.slot_cs = '0;
    bus.slot_addr = '0;
    rst = 1'b0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      logic [3:0] pend;
      logic [3:0] eok;
      bit         ack, rdy, dl;
      logic [3:0] cs;
      @(negedge clk);
      cs  = 4'($urandom_range(0, 15));
      dl  = ($urandom_range(0, 49) == 0);
      ack = ($urandom_range(0, 1) == 1);
      rdy = ($urandom_range(0, 9) < 4);
      for (int i = 0; i < NS; i++)
        if ($urandom_range(0, 7) == 0) set_addr(i, 22'($urandom_range(0, 3)));
      bus.slot_cs     = cs;
      bus.downloading = dl;
      bus.sdram_ack   = ack;
      bus.data_rdy    = rdy;
      bus.data_read   = $urandom;
      #1;
      for (int i = 0; i < NS; i++) begin
        logic h;
        h       = m_valid[i] && (m_tag[i] == get_addr(i)) && !dl;
        eok[i]  = cs[i] && h;
        pend[i] = cs[i] && !h && !dl;
      end
      chk("rnd req", 128'(bus.sdram_req), 128'(m_busy && !m_acked));
      chk("rnd addr", 128'(bus.sdram_addr), 128'(m_raddr));
      chk("rnd ok", 128'(bus.slot_ok), 128'(eok));
      chk("rnd refresh", 128'(bus.refresh_en), 128'(!m_busy && pend == 4'b0));
      chk("rnd dout", 128'(bus.slot_dout), {m_data[3], m_data[2], m_data[1], m_data[0]});
      // advance the model to the state after the coming clock edge
      if (dl) begin
        for (int i = 0; i < NS; i++) m_valid[i] = 1'b0;
        m_busy = 0;
      end else if (!m_busy) begin
        if (pend != 4'b0) begin
          m_g     = pick(pend, m_rr);
          m_rr    = m_g;
          m_busy  = 1;
          m_acked = 0;
          m_gaddr = get_addr(m_g);
          m_raddr = 22'(m_gaddr + OFFS[m_g]);
        end
      end else begin
        bit got;
        got = 0;
        if (!m_acked) begin
          if (ack) begin
            m_acked = 1;
            got = rdy;
          end
        end else begin
          got = rdy;
        end
        if (got) begin
          m_valid[m_g] = 1'b1;
          m_tag[m_g]   = m_gaddr;
          m_data[m_g]  = bus.data_read;
          m_busy       = 0;
        end
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
